// File: rtl/sine_nco_pkg.sv
// ============================================================================
// sine_nco_pkg
//   Shared types and constants for the sine NCO table reader.
//   Rev 1.0
// ============================================================================
`default_nettype none

package sine_nco_pkg;

   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
   localparam int CREDIT_W   = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LOAD = 2'd2
   } nco_state_e;

   // Slots already claimed (buffered + in flight), less the one leaving now,
   // must leave room for one more read.
   function automatic logic credit_avail(
      input logic [CREDIT_W-1:0] fifo_count,
      input logic [CREDIT_W-1:0] inflight,
      input logic                pop
   );
      logic [CREDIT_W:0] occ;
      occ = {1'b0, fifo_count} + {1'b0, inflight} - {{CREDIT_W{1'b0}}, pop};
      return occ < (CREDIT_W + 1)'(FIFO_DEPTH);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sine_sample_fifo.sv
// ============================================================================
// sine_sample_fifo
//   Small show-ahead synchronous FIFO holding samples returned by the RAM.
//   Rev 1.0
// ============================================================================
`default_nettype none

module sine_sample_fifo
   import sine_nco_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic [DW-1:0]       din,
   input  logic                pop,
   output logic [DW-1:0]       dout,
   output logic                valid,
   output logic [CREDIT_W-1:0] count
);

   logic [DW-1:0]       r_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]  r_wr_ptr;
   logic [FIFO_AW-1:0]  r_rd_ptr;
   logic [CREDIT_W-1:0] r_count;
   logic                w_do_push;
   logic                w_do_pop;

   assign w_do_pop  = pop && (r_count != '0);
   assign w_do_push = push && ((r_count != CREDIT_W'(FIFO_DEPTH)) || w_do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CREDIT_W'(1);
            2'b01:   r_count <= r_count - CREDIT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign valid = (r_count != '0);
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/sine_nco_reader.sv
// ============================================================================
// sine_nco_reader
//   Drives a read-first sine-table RAM: NCO sample streaming or table reload.
//   Rev 1.0
// ============================================================================
`default_nettype none

module sine_nco_reader
   import sine_nco_pkg::*;
#(
   parameter  int DW    = 8,
   parameter  int WORDS = 256,
   parameter  int PW    = 32,
   localparam int AW    = $clog2(WORDS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 load_start,
   input  logic                 phase_clr,
   input  logic [PW-1:0]        freq_word,
   input  logic [AW-1:0]        phase_ofs,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic signed [DW-1:0] s_data,
   output logic [AW-1:0]        ram_addr,
   output logic                 ram_we,
   output logic signed [DW-1:0] ram_din,
   input  logic signed [DW-1:0] ram_qout,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic signed [DW-1:0] m_data
);

   nco_state_e          r_state;
   nco_state_e          w_next_state;

   logic [PW-1:0]       r_acc;
   logic [AW-1:0]       r_load_cnt;
   logic                r_rd_v1;
   logic                r_rd_v2;

   logic [CREDIT_W-1:0] w_fifo_count;
   logic [CREDIT_W-1:0] w_inflight;
   logic                w_pop;
   logic                w_credit_ok;
   logic                w_issue;
   logic                w_load_accept;
   logic                w_load_last;

   assign w_pop       = m_valid && m_ready;
   assign w_inflight  = {{(CREDIT_W-1){1'b0}}, r_rd_v1} + {{(CREDIT_W-1){1'b0}}, r_rd_v2};
   assign w_credit_ok = credit_avail(w_fifo_count, w_inflight, w_pop);
   assign w_load_last = w_load_accept && (r_load_cnt == AW'(WORDS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            // A reload must not race reads still travelling through the RAM.
            if (load_start && (w_inflight == '0)) begin
               w_next_state = LOAD;
            end else if (enable) begin
               w_next_state = RUN;
            end
         end
         RUN: begin
            if (!enable) begin
               w_next_state = IDLE;
            end
         end
         LOAD: begin
            if (w_load_last) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      s_ready       = 1'b0;
      w_issue       = 1'b0;
      w_load_accept = 1'b0;
      case (r_state)
         RUN: begin
            w_issue = enable && w_credit_ok;
         end
         LOAD: begin
            s_ready       = 1'b1;
            w_load_accept = s_valid;
         end
         default: begin
            s_ready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_load_cnt <= '0;
         r_rd_v1    <= 1'b0;
         r_rd_v2    <= 1'b0;
         ram_addr   <= '0;
         ram_we     <= 1'b0;
         ram_din    <= '0;
      end else begin
         // RAM output lands one cycle after the address; r_rd_v2 marks it.
         r_rd_v1 <= w_issue;
         r_rd_v2 <= r_rd_v1;
         ram_we  <= 1'b0;

         if (phase_clr) begin
            r_acc <= '0;
         end else if (w_issue) begin
            r_acc <= r_acc + freq_word;
         end

         if (w_issue) begin
            ram_addr <= r_acc[PW-1 -: AW] + phase_ofs;
         end else if (w_load_accept) begin
            ram_addr   <= r_load_cnt;
            ram_din    <= s_data;
            ram_we     <= 1'b1;
            r_load_cnt <= w_load_last ? '0 : r_load_cnt + AW'(1);
         end
      end
   end

   sine_sample_fifo #(
      .DW(DW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (r_rd_v2),
      .din   (ram_qout),
      .pop   (w_pop),
      .dout  (m_data),
      .valid (m_valid),
      .count (w_fifo_count)
   );

endmodule

`default_nettype wire

// File: tb/tb_sine_nco_reader.sv
// ============================================================================
// tb_sine_nco_reader
//   Directed bench for sine_nco_reader with a read-first sine RAM model.
//   Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module SpRamRfSine #(
   parameter int DW    = 8,
   parameter int WORDS = 256
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(WORDS)-1:0]     addr,
   input  logic signed [DW-1:0]         din,
   output logic signed [DW-1:0]         qout
);
   localparam real PI = 3.14159265358979323846;
   logic signed [DW-1:0] mem [WORDS];

   initial begin
      for (int k = 0; k < WORDS; k++) begin
         real r;
         r = 127.0 * $sin(2.0 * PI * k / WORDS);
         r = r + ((r >= 0.0) ? 1.0e-9 : -1.0e-9);
         mem[k] = DW'($rtoi(r));
      end
   end

   always @(posedge clk) begin
      qout <= mem[addr];
      if (we) mem[addr] <= din;
   end
endmodule

module tb_sine_nco_reader;
   localparam real PI = 3.14159265358979323846;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        load_start;
   logic        phase_clr;
   logic [31:0] freq_word;
   logic [7:0]  phase_ofs;
   logic        s_valid;
   logic        s_ready;
   logic signed [7:0] s_data;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic signed [7:0] ram_din;
   logic signed [7:0] ram_qout;
   logic        m_valid;
   logic        m_ready;
   logic signed [7:0] m_data;

   wire [7:0] md = m_data;
   wire [7:0] dn = ram_din;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] sine_ref [256];
   bit         mon_en;
   bit         mon_ident;
   logic [7:0] mon_addr;
   logic [7:0] mon_step;
   logic [7:0] rebase_addr;
   int         rebase_in;
   int         pops;
   int         we_cnt;

   sine_nco_reader #(.DW(8), .WORDS(256), .PW(32)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load_start(load_start),
      .phase_clr(phase_clr), .freq_word(freq_word), .phase_ofs(phase_ofs),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_qout(ram_qout),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
   );

   SpRamRfSine #(.DW(8), .WORDS(256)) u_ram (
      .clk(clk), .we(ram_we), .addr(ram_addr), .din(ram_din), .qout(ram_qout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      enable     = 1'b0;
      load_start = 1'b0;
      phase_clr  = 1'b0;
      s_valid    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!m_valid && n < 12) begin
         step();
         n++;
      end
      check_vec(tag, {31'd0, m_valid}, 32'd1);
   endtask

   // Stream scoreboard: every accepted sample must follow the modelled address walk.
   always @(negedge clk) begin
      if (mon_en && m_valid && m_ready) begin
         check_vec("stream", {24'd0, md}, {24'd0, mon_ident ? mon_addr : sine_ref[mon_addr]});
         mon_addr = mon_addr + mon_step;
         if (rebase_in == 1) mon_addr = rebase_addr;
         if (rebase_in > 0) rebase_in--;
         pops++;
      end
      if (ram_we) begin
         check_vec("we_addr", {24'd0, ram_addr}, {24'd0, we_cnt[7:0]});
         check_vec("we_data", {24'd0, dn}, {24'd0, we_cnt[7:0]});
         we_cnt++;
      end
   end

   initial begin
      int p0;
      int k;
      int guard;
      bit took;

      for (int i = 0; i < 256; i++) begin
         real r;
         r = 127.0 * $sin(2.0 * PI * i / 256);
         r = r + ((r >= 0.0) ? 1.0e-9 : -1.0e-9);
         sine_ref[i] = 8'($rtoi(r));
      end
      mon_en = 0; mon_ident = 0; mon_addr = 0; mon_step = 1;
      rebase_addr = 0; rebase_in = 0; pops = 0; we_cnt = 0;
      freq_word = 32'h0100_0000; phase_ofs = 8'd0; m_ready = 1'b1; s_data = 0;

      // Reset values
      do_reset();
      check_vec("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check_vec("rst_m_data", {24'd0, md}, 32'd0);
      check_vec("rst_ram_we", {31'd0, ram_we}, 32'd0);
      check_vec("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
      check_vec("rst_ram_din", {24'd0, dn}, 32'd0);
      check_vec("rst_s_ready", {31'd0, s_ready}, 32'd0);

      // Step-1 sweep and first-sample latency
      mon_addr = 0; mon_step = 1; mon_en = 1;
      enable = 1'b1;
      step(); check_vec("lat_e1", {31'd0, m_valid}, 32'd0);
      step(); check_vec("lat_e2", {31'd0, m_valid}, 32'd0);
      step(); check_vec("lat_e3", {31'd0, m_valid}, 32'd0);
      step(); check_vec("lat_e4", {31'd0, m_valid}, 32'd1);
      check_vec("s1_k0", {24'd0, md}, 32'h00);
      step(); check_vec("s1_k1", {24'd0, md}, 32'h03);
      step(); check_vec("s1_k2", {24'd0, md}, 32'h06);
      step(); check_vec("s1_k3", {24'd0, md}, 32'h09);
      repeat (10) step();

      // Backpressure: buffer fills, address stalls, output holds
      m_ready = 1'b0;
      repeat (6) step();
      check_vec("bp_addr6", {24'd0, ram_addr}, {24'd0, mon_addr + 8'd3});
      check_vec("bp_hold6", {24'd0, md}, {24'd0, sine_ref[mon_addr]});
      repeat (4) step();
      check_vec("bp_addr10", {24'd0, ram_addr}, {24'd0, mon_addr + 8'd3});
      check_vec("bp_hold10", {24'd0, md}, {24'd0, sine_ref[mon_addr]});
      check_vec("bp_valid", {31'd0, m_valid}, 32'd1);
      p0 = pops;
      m_ready = 1'b1;
      repeat (12) step();
      check_vec("bp_rate", pops - p0, 32'd12);

      // phase_clr while stalled: buffered samples finish, then restart at offset
      m_ready = 1'b0;
      repeat (8) step();
      phase_ofs = 8'h20;
      phase_clr = 1'b1;
      step();
      phase_clr = 1'b0;
      rebase_addr = 8'h20; rebase_in = 4;
      p0 = pops;
      m_ready = 1'b1;
      repeat (12) step();
      check_vec("clr_rate", pops - p0, 32'd12);
      enable = 1'b0;
      repeat (10) step();
      mon_en = 0;

      // Nyquist with quarter-wave offset
      do_reset();
      freq_word = 32'h8000_0000; phase_ofs = 8'd64;
      enable = 1'b1;
      wait_valid("nyq_valid");
      check_vec("nyq_0", {24'd0, md}, 32'h7F);
      step(); check_vec("nyq_1", {24'd0, md}, 32'h81);
      step(); check_vec("nyq_2", {24'd0, md}, 32'h7F);
      step(); check_vec("nyq_3", {24'd0, md}, 32'h81);
      enable = 1'b0;
      repeat (10) step();

      // Negative step wraps the accumulator
      do_reset();
      freq_word = 32'hFF00_0000; phase_ofs = 8'd0;
      mon_addr = 0; mon_step = 8'hFF; mon_en = 1;
      enable = 1'b1;
      wait_valid("wrap_valid");
      check_vec("wrap_0", {24'd0, md}, 32'h00);
      step(); check_vec("wrap_1", {24'd0, md}, 32'hFD);
      step(); check_vec("wrap_2", {24'd0, md}, 32'hFA);
      repeat (280) step();

      // Reset while streaming
      check_vec("mid_pre_valid", {31'd0, m_valid}, 32'd1);
      mon_en = 0;
      rst_n = 1'b0;
      freq_word = 32'h0100_0000; phase_ofs = 8'd10;
      step();
      rst_n = 1'b1;
      check_vec("mid_m_valid", {31'd0, m_valid}, 32'd0);
      check_vec("mid_ram_we", {31'd0, ram_we}, 32'd0);
      check_vec("mid_s_ready", {31'd0, s_ready}, 32'd0);
      mon_addr = 8'd10; mon_step = 1; mon_en = 1;
      wait_valid("mid_valid");
      check_vec("mid_first", {24'd0, md}, 32'h1E);
      repeat (20) step();
      enable = 1'b0;
      repeat (10) step();
      mon_en = 0;

      // Table reload with gapped input
      do_reset();
      we_cnt = 0;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      check_vec("ld_ready", {31'd0, s_ready}, 32'd1);
      k = 0; guard = 0;
      while (k < 256 && guard < 2000) begin
         s_data  = 8'(k);
         s_valid = ($urandom_range(0, 3) != 0);
         took    = s_valid && s_ready;
         step();
         if (took) k++;
         guard++;
      end
      s_valid = 1'b0;
      check_vec("ld_words", k, 32'd256);
      check_vec("ld_ready_done", {31'd0, s_ready}, 32'd0);
      repeat (2) step();
      check_vec("ld_we_cnt", we_cnt, 32'd256);

      // Read back the reloaded table as a step-1 stream
      freq_word = 32'h0100_0000; phase_ofs = 8'd0;
      mon_ident = 1; mon_addr = 0; mon_step = 1; mon_en = 1;
      p0 = pops;
      enable = 1'b1;
      guard = 0;
      while ((pops - p0) < 257 && guard < 400) begin
         step();
         guard++;
      end
      check_vec("ld_run_cnt", {31'd0, (pops - p0) >= 257}, 32'd1);
      enable = 1'b0;
      repeat (10) step();
      mon_en = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
